rv32i_datapath: RTL and testbench
=================================

# rv32i_datapath

Execution datapath for the rv32i multicycle core: a 32-bit enable-gated program-counter register, a 32×32 register file with hardwired-zero x0, and a purely combinational ALU. The core's control FSM sequences it, driving PC update, register read/write addresses and ALU operands/control. The block holds no control state of its own.

## Interface
- PC_START_ADDRESS, default 0: value loaded into the PC register on reset.
- clk  in  1  rising-edge clock for all state.
- rst  in  1  reset. Synchronous and active-high: a single clock domain on `clk`, with `rst` sampled only at the rising edge.
- pc_ena  in  1  PC load enable.
- pc_next  in  32  next PC value.
- pc  out  32  current PC.
- rf_wr_ena  in  1  register-file write enable.
- rf_wr_addr  in  5  write register index (rd).
- rf_wr_data  in  32  write data.
- rf_rd_addr0, rf_rd_addr1  in  5 each  read indices (rs1, rs2).
- rf_rd_data0, rf_rd_data1  out  32 each  read data.
- alu_a, alu_b  in  32 each  ALU operands.
- alu_control  in  4  ALU operation (alu_control_t).
- alu_result  out  32  ALU result.
- overflow, zero, equal  out  1 each  ALU flags.

## Operation
- PC register:
  - `rst` gives `pc` = PC_START_ADDRESS; `rst` has priority over `pc_ena`.
  - Otherwise `pc` loads `pc_next` when `pc_ena` = 1 and holds when it is 0.
- Register file storage and reset:
  - 32 entries of 32 bits.
  - `rst` clears x1..x31 to 0.
- Register file write: when `rf_wr_ena` = 1 and `rf_wr_addr` ≠ 0, the entry is written at the clock edge. Writes to x0 are discarded.
- Register file read: both read ports are combinational (asynchronous). Index 0 always reads 0.
- ALU encoding (4 bits):
  - INVALID = 0000
  - AND = 0001, OR = 0010, XOR = 0011
  - SLL = 0101, SRL = 0110, SRA = 0111
  - ADD = 1000, SUB = 1100
  - SLT = 1101, SLTU = 1111
- ALU operations:
  - ADD/SUB: modulo 2^32.
  - SLL/SRL/SRA: shift by `alu_b[4:0]` only; SRA sign-fills from `alu_a[31]`.
  - SLT: signed compare; SLTU: unsigned compare. Both give 32'd1 or 32'd0.
  - INVALID or any unlisted code: `alu_result` = 0.
- ALU flags:
  - `overflow`: signed overflow, for ADD/SUB only. ADD: operands share a sign and the result sign differs. SUB: operands differ in sign and the result sign differs from `alu_a`. It is 0 for every other operation.
  - `zero` = (`alu_result` == 0).
  - `equal` = (`alu_a` == `alu_b`), regardless of `alu_control`.

## Timing
- ALU: zero-latency combinational; outputs settle within the same cycle as operand or control changes.
- Register file read: combinational from address to data.
- Register file write: visible on the read ports from the cycle after the write edge. In the write cycle itself the read ports return the old value (unless RF_WRITE_BYPASS_EN is defined).
- PC: `pc` updates one edge after `pc_ena` is sampled high.
- Reset outputs: `pc` = PC_START_ADDRESS; all register reads = 0; ALU outputs follow their inputs.
- Reset asserted mid-operation: state is overwritten at that edge. A write presented in the same cycle as `rst` is dropped.
- Both read ports addressing the same register: both return identical data.

## Configuration
- RF_WRITE_BYPASS_EN, when defined: a read port whose address equals a nonzero `rf_wr_addr` while `rf_wr_ena` = 1 returns `rf_wr_data` combinationally in that same cycle.
- When not defined: no bypass; the read ports return the stored value.
- x0 always reads 0 in both modes.

## Test plan
- PC reset and enable: PC_START_ADDRESS = 32'h100, `rst` held one cycle → `pc` = 0x100. Then `pc_next` = 0x104 with `pc_ena` = 0 → `pc` stays 0x100. Then `pc_ena` = 1 → `pc` = 0x104 at the next edge.
- Register file write/read: write x5 = 0xDEADBEEF, then read x5 on both ports → 0xDEADBEEF. Write x0 = 0x1234 → x0 reads 0. Apply `rst` → x5 reads 0.
- Same-cycle read-during-write: read x7 (holding 0x1) while writing x7 = 0x2 → 0x1 without the macro, 0x2 with RF_WRITE_BYPASS_EN. After the edge, both modes read 0x2.
- Add/subtract overflow:
  - ADD 0x7FFFFFFF + 1 → 0x80000000, `overflow` = 1.
  - SUB 5 − 5 → 0, `zero` = 1, `equal` = 1.
  - SUB 0x80000000 − 1 → 0x7FFFFFFF, `overflow` = 1.
- Shifts with `alu_a` = 0x80000000 and `alu_b` = 0x21 (shift amount 1): SRA → 0xC0000000, SRL → 0x40000000, SLL → 0.
- Compares and INVALID:
  - SLT −1 < 1 → 1; SLTU 0xFFFFFFFF < 1 → 0.
  - INVALID with any operands → result 0, `zero` = 1, `overflow` = 0.

Source files
------------

// File: rtl/rv32i_datapath_if.sv
// rv32i_datapath_if: control-to-datapath bundle for the rv32i multicycle core.
// The master side (the control FSM) drives PC update, register-file addresses
// and write data, and the ALU operands and operation. The slave side (the
// datapath) returns the current PC, both read ports, the ALU result and flags.
interface rv32i_datapath_if;
    logic        pc_ena;
    logic [31:0] pc_next;
    logic [31:0] pc;

    logic        rf_wr_ena;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic [4:0]  rf_rd_addr0;
    logic [4:0]  rf_rd_addr1;
    logic [31:0] rf_rd_data0;
    logic [31:0] rf_rd_data1;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        overflow;
    logic        zero;
    logic        equal;

    modport master (
        output pc_ena, pc_next,
        output rf_wr_ena, rf_wr_addr, rf_wr_data, rf_rd_addr0, rf_rd_addr1,
        output alu_a, alu_b, alu_control,
        input  pc, rf_rd_data0, rf_rd_data1,
        input  alu_result, overflow, zero, equal
    );

    modport slave (
        input  pc_ena, pc_next,
        input  rf_wr_ena, rf_wr_addr, rf_wr_data, rf_rd_addr0, rf_rd_addr1,
        input  alu_a, alu_b, alu_control,
        output pc, rf_rd_data0, rf_rd_data1,
        output alu_result, overflow, zero, equal
    );
endinterface

// File: rtl/rv32i_datapath.sv
// rv32i_datapath: PC register, 32x32 register file (x0 hardwired to zero) and
// combinational ALU for the rv32i multicycle core. No control state lives here.
// Optional feature macro: RF_WRITE_BYPASS_EN -- when defined, a read port whose
// address matches an active nonzero write returns the write data in the same
// cycle; otherwise reads return the stored value.
module rv32i_datapath #(
    parameter logic [31:0] PC_START_ADDRESS = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    rv32i_datapath_if.slave  dp
);

    typedef enum logic [3:0] {
        ALU_INVALID = 4'b0000,
        ALU_AND     = 4'b0001,
        ALU_OR      = 4'b0010,
        ALU_XOR     = 4'b0011,
        ALU_SLL     = 4'b0101,
        ALU_SRL     = 4'b0110,
        ALU_SRA     = 4'b0111,
        ALU_ADD     = 4'b1000,
        ALU_SUB     = 4'b1100,
        ALU_SLT     = 4'b1101,
        ALU_SLTU    = 4'b1111
    } alu_control_t;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] rf_q [32];

    logic [31:0] sum;
    logic [31:0] diff;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic        alu_ovf;

    // PC next-state: load when enabled, otherwise hold.
    always_comb begin
        pc_d = dp.pc_ena ? dp.pc_next : pc_q;
    end

    // PC register with synchronous reset to the start address.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= PC_START_ADDRESS;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign dp.pc = pc_q;

    // Register file storage: reset clears all entries, writes to x0 are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (dp.rf_wr_ena && (dp.rf_wr_addr != 5'd0)) begin
            rf_q[dp.rf_wr_addr] <= dp.rf_wr_data;
        end
    end

    function automatic logic [31:0] rf_read(input logic [4:0] addr);
        logic [31:0] val;
        val = (addr == 5'd0) ? '0 : rf_q[addr];
`ifdef RF_WRITE_BYPASS_EN
        if (dp.rf_wr_ena && (dp.rf_wr_addr != 5'd0) && (dp.rf_wr_addr == addr)) begin
            val = dp.rf_wr_data;
        end
`endif
        return val;
    endfunction

    // Asynchronous read ports.
    always_comb begin
        dp.rf_rd_data0 = rf_read(dp.rf_rd_addr0);
        dp.rf_rd_data1 = rf_read(dp.rf_rd_addr1);
    end

    // ALU: result and signed-overflow flag, overflow meaningful only for ADD/SUB.
    always_comb begin
        sum     = dp.alu_a + dp.alu_b;
        diff    = dp.alu_a - dp.alu_b;
        shamt   = dp.alu_b[4:0];
        alu_res = '0;
        alu_ovf = 1'b0;
        case (dp.alu_control)
            ALU_AND:  alu_res = dp.alu_a & dp.alu_b;
            ALU_OR:   alu_res = dp.alu_a | dp.alu_b;
            ALU_XOR:  alu_res = dp.alu_a ^ dp.alu_b;
            ALU_SLL:  alu_res = dp.alu_a << shamt;
            ALU_SRL:  alu_res = dp.alu_a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(dp.alu_a) >>> shamt);
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (dp.alu_a[31] == dp.alu_b[31]) && (sum[31] != dp.alu_a[31]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (dp.alu_a[31] != dp.alu_b[31]) && (diff[31] != dp.alu_a[31]);
            end
            ALU_SLT:  alu_res = {31'd0, ($signed(dp.alu_a) < $signed(dp.alu_b))};
            ALU_SLTU: alu_res = {31'd0, (dp.alu_a < dp.alu_b)};
            default:  alu_res = '0;
        endcase
    end

    // ALU outputs and flags.
    always_comb begin
        dp.alu_result = alu_res;
        dp.overflow   = alu_ovf;
        dp.zero       = (alu_res == 32'd0);
        dp.equal      = (dp.alu_a == dp.alu_b);
    end

endmodule

// File: tb/tb_rv32i_datapath.sv
// tb_rv32i_datapath: directed test-plan cases plus randomized cycles checked
// against an arithmetic reference model of the PC, register file and ALU.
module tb_rv32i_datapath;

    localparam logic [31:0] START = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst;

    rv32i_datapath_if dpif ();

    rv32i_datapath #(.PC_START_ADDRESS(START)) dut (
        .clk (clk),
        .rst (rst),
        .dp  (dpif.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] pc_m;
    logic [31:0] rf_m [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference ALU from the operation definitions using wide signed arithmetic.
    task automatic alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic ovf);
        longint s;
        int unsigned sh;
        sh  = int'(b % 32);
        res = 32'd0;
        ovf = 1'b0;
        case (op)
            4'd1:  res = a & b;
            4'd2:  res = a | b;
            4'd3:  res = a ^ b;
            4'd5:  res = 32'(longint'(a) * (longint'(1) << sh));
            4'd6:  res = 32'(longint'(a) / (longint'(1) << sh));
            4'd7:  res = a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd8: begin
                s   = longint'($signed(a)) + longint'($signed(b));
                res = s[31:0];
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd12: begin
                s   = longint'($signed(a)) - longint'($signed(b));
                res = s[31:0];
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd13: res = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            4'd15: res = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            default: res = 32'd0;
        endcase
    endtask

    function automatic logic [31:0] rd_exp(input logic [4:0] addr);
        if (addr == 5'd0) return 32'd0;
`ifdef RF_WRITE_BYPASS_EN
        if (dpif.rf_wr_ena && dpif.rf_wr_addr == addr) return dpif.rf_wr_data;
`endif
        return rf_m[addr];
    endfunction

    // Check combinational outputs, take one clock edge, update the model, check PC.
    task automatic cycle();
        logic [31:0] r;
        logic        o;
        #1;
        chk("rd0", dpif.rf_rd_data0, rd_exp(dpif.rf_rd_addr0));
        chk("rd1", dpif.rf_rd_data1, rd_exp(dpif.rf_rd_addr1));
        alu_ref(dpif.alu_control, dpif.alu_a, dpif.alu_b, r, o);
        chk("alu_result", dpif.alu_result, r);
        chk("overflow", 32'(dpif.overflow), 32'(o));
        chk("zero", 32'(dpif.zero), 32'(r == 32'd0));
        chk("equal", 32'(dpif.equal), 32'(dpif.alu_a == dpif.alu_b));
        @(posedge clk);
        if (rst) begin
            pc_m = START;
            for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
        end else begin
            if (dpif.pc_ena) pc_m = dpif.pc_next;
            if (dpif.rf_wr_ena && dpif.rf_wr_addr != 5'd0) rf_m[dpif.rf_wr_addr] = dpif.rf_wr_data;
        end
        #1;
        chk("pc", dpif.pc, pc_m);
    endtask

    task automatic alu_dir(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] er, input logic eo,
                           input logic ez, input logic ee);
        dpif.alu_control = op;
        dpif.alu_a = a;
        dpif.alu_b = b;
        #1;
        chk({tag, "_res"}, dpif.alu_result, er);
        chk({tag, "_ovf"}, 32'(dpif.overflow), 32'(eo));
        chk({tag, "_zero"}, 32'(dpif.zero), 32'(ez));
        chk({tag, "_eq"}, 32'(dpif.equal), 32'(ee));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        dpif.pc_ena = 1'b0;
        dpif.pc_next = 32'd0;
        dpif.rf_wr_ena = 1'b0;
        dpif.rf_wr_addr = 5'd0;
        dpif.rf_wr_data = 32'd0;
        dpif.rf_rd_addr0 = 5'd0;
        dpif.rf_rd_addr1 = 5'd0;
        dpif.alu_a = 32'd0;
        dpif.alu_b = 32'd0;
        dpif.alu_control = 4'd0;
        for (int i = 0; i < 32; i++) rf_m[i] = 32'hxxxx_xxxx;

        // Reset
        cycle();
        rst = 1'b0;
        chk("pc_reset", dpif.pc, START);

        // PC hold then load
        dpif.pc_next = 32'h104;
        dpif.pc_ena = 1'b0;
        cycle();
        chk("pc_hold", dpif.pc, 32'h100);
        dpif.pc_ena = 1'b1;
        cycle();
        chk("pc_load", dpif.pc, 32'h104);
        dpif.pc_ena = 1'b0;

        // Register file write/read, x0 write, reset clear
        dpif.rf_wr_ena = 1'b1;
        dpif.rf_wr_addr = 5'd5;
        dpif.rf_wr_data = 32'hDEAD_BEEF;
        cycle();
        dpif.rf_wr_ena = 1'b0;
        dpif.rf_rd_addr0 = 5'd5;
        dpif.rf_rd_addr1 = 5'd5;
        #1;
        chk("x5_port0", dpif.rf_rd_data0, 32'hDEAD_BEEF);
        chk("x5_port1", dpif.rf_rd_data1, 32'hDEAD_BEEF);
        dpif.rf_wr_ena = 1'b1;
        dpif.rf_wr_addr = 5'd0;
        dpif.rf_wr_data = 32'h1234;
        cycle();
        dpif.rf_wr_ena = 1'b0;
        dpif.rf_rd_addr0 = 5'd0;
        #1;
        chk("x0_zero", dpif.rf_rd_data0, 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        dpif.rf_rd_addr1 = 5'd5;
        #1;
        chk("x5_after_rst", dpif.rf_rd_data1, 32'd0);

        // Same-cycle read during write
        dpif.rf_wr_ena = 1'b1;
        dpif.rf_wr_addr = 5'd7;
        dpif.rf_wr_data = 32'h1;
        cycle();
        dpif.rf_wr_data = 32'h2;
        dpif.rf_rd_addr0 = 5'd7;
        #1;
`ifdef RF_WRITE_BYPASS_EN
        chk("rdw_same", dpif.rf_rd_data0, 32'h2);
`else
        chk("rdw_same", dpif.rf_rd_data0, 32'h1);
`endif
        cycle();
        dpif.rf_wr_ena = 1'b0;
        #1;
        chk("rdw_after", dpif.rf_rd_data0, 32'h2);

        // ALU directed cases
        alu_dir("add_ovf",  4'b1000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        alu_dir("sub_zero", 4'b1100, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1'b1);
        alu_dir("sub_ovf",  4'b1100, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
        alu_dir("sra",      4'b0111, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0, 1'b0, 1'b0);
        alu_dir("srl",      4'b0110, 32'h8000_0000, 32'h21, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
        alu_dir("sll",      4'b0101, 32'h8000_0000, 32'h21, 32'h0, 1'b0, 1'b1, 1'b0);
        alu_dir("slt",      4'b1101, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
        alu_dir("sltu",     4'b1111, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0);
        alu_dir("invalid",  4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0);

        // Randomized cycles against the reference model
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            dpif.pc_ena = 1'($urandom_range(0, 1));
            dpif.pc_next = $urandom;
            dpif.rf_wr_ena = 1'($urandom_range(0, 1));
            dpif.rf_wr_addr = 5'($urandom_range(0, 31));
            dpif.rf_wr_data = $urandom;
            dpif.rf_rd_addr0 = ($urandom_range(0, 3) == 0) ? dpif.rf_wr_addr : 5'($urandom_range(0, 31));
            dpif.rf_rd_addr1 = ($urandom_range(0, 3) == 0) ? dpif.rf_rd_addr0 : 5'($urandom_range(0, 31));
            dpif.alu_a = pick();
            dpif.alu_b = ($urandom_range(0, 7) == 0) ? dpif.alu_a : pick();
            dpif.alu_control = 4'($urandom_range(0, 15));
            cycle();
            chk("ports_same", 32'(dpif.rf_rd_addr0 != dpif.rf_rd_addr1 || dpif.rf_rd_data0 == dpif.rf_rd_data1), 32'd1);
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
